// File: rtl/ram_dump_reader_if.sv
// Output word stream of the RAM dump reader.
// Carries data, address and beat markers under valid/ready.
interface ram_dump_reader_if #(
  parameter int N         = 64,
  parameter int ADDR_BITS = 4
);
  logic [N-1:0]         dout;
  logic [ADDR_BITS-1:0] dout_addr;
  logic                 dout_valid;
  logic                 dout_ready;
  logic                 dout_last;
  logic                 dout_csum;

  modport master (
    output dout,
    output dout_addr,
    output dout_valid,
    output dout_last,
    output dout_csum,
    input  dout_ready
  );

  modport slave (
    input  dout,
    input  dout_addr,
    input  dout_valid,
    input  dout_last,
    input  dout_csum,
    output dout_ready
  );
endinterface

// File: rtl/ram_dump_reader.sv
// Walks an inclusive, wrapping RAM address range and streams each word out.
// Define RAM_DUMP_CHECKSUM_EN to append an XOR checksum beat.
module ram_dump_reader #(
  parameter int N         = 64,
  parameter int ADDR_BITS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [ADDR_BITS-1:0] start_addr,
  input  logic [ADDR_BITS-1:0] last_addr,
  output logic                 rd_en,
  output logic [ADDR_BITS-1:0] rd_addr,
  input  logic [N-1:0]         rd_data,
  ram_dump_reader_if.master    dout_if,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    SEND,
    CSUM
  } state_t;

  localparam logic [ADDR_BITS:0]   REM_ONE  = 1;
  localparam logic [ADDR_BITS-1:0] ADDR_ONE = 1;

  state_t               state;
  logic [ADDR_BITS-1:0] cur;
  logic [ADDR_BITS:0]   rem;
  logic [ADDR_BITS-1:0] span;
  logic [ADDR_BITS-1:0] nxt;
  logic                 xfer;
`ifdef RAM_DUMP_CHECKSUM_EN
  logic [N-1:0]         acc;
`endif

  // Word count minus one; the mod-2^ADDR_BITS wrap is the width itself.
  assign span = last_addr - start_addr;
  assign nxt  = cur + ADDR_ONE;
  assign xfer = dout_if.dout_valid & dout_if.dout_ready;
  assign busy = (state != IDLE);

`ifndef RAM_DUMP_CHECKSUM_EN
  assign dout_if.dout_csum = 1'b0;
`endif

  // Dump sequencer: one read, one capture, then hold until accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      cur                <= '0;
      rem                <= '0;
      rd_en              <= 1'b0;
      rd_addr            <= '0;
      done               <= 1'b0;
      dout_if.dout       <= '0;
      dout_if.dout_addr  <= '0;
      dout_if.dout_valid <= 1'b0;
      dout_if.dout_last  <= 1'b0;
`ifdef RAM_DUMP_CHECKSUM_EN
      dout_if.dout_csum  <= 1'b0;
      acc                <= '0;
`endif
    end else begin
      rd_en <= 1'b0;
      done  <= 1'b0;
      if (abort && state != IDLE) begin
        state              <= IDLE;
        dout_if.dout_valid <= 1'b0;
        dout_if.dout_last  <= 1'b0;
`ifdef RAM_DUMP_CHECKSUM_EN
        dout_if.dout_csum  <= 1'b0;
`endif
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              cur     <= start_addr;
              rem     <= {1'b0, span} + REM_ONE;
              rd_en   <= 1'b1;
              rd_addr <= start_addr;
              state   <= READ;
`ifdef RAM_DUMP_CHECKSUM_EN
              acc     <= '0;
`endif
            end
          end
          READ: begin
            state <= WAIT;
          end
          WAIT: begin
            dout_if.dout       <= rd_data;
            dout_if.dout_addr  <= cur;
            dout_if.dout_valid <= 1'b1;
`ifdef RAM_DUMP_CHECKSUM_EN
            dout_if.dout_last  <= 1'b0;
            dout_if.dout_csum  <= 1'b0;
`else
            dout_if.dout_last  <= (rem == REM_ONE);
`endif
            state <= SEND;
          end
          SEND: begin
            if (xfer) begin
              dout_if.dout_valid <= 1'b0;
              dout_if.dout_last  <= 1'b0;
`ifdef RAM_DUMP_CHECKSUM_EN
              acc <= acc ^ dout_if.dout;
`endif
              if (rem != REM_ONE) begin
                cur     <= nxt;
                rem     <= rem - REM_ONE;
                rd_en   <= 1'b1;
                rd_addr <= nxt;
                state   <= READ;
              end else begin
`ifdef RAM_DUMP_CHECKSUM_EN
                dout_if.dout       <= acc ^ dout_if.dout;
                dout_if.dout_addr  <= '0;
                dout_if.dout_valid <= 1'b1;
                dout_if.dout_last  <= 1'b1;
                dout_if.dout_csum  <= 1'b1;
                state              <= CSUM;
`else
                done  <= 1'b1;
                state <= IDLE;
`endif
              end
            end
          end
`ifdef RAM_DUMP_CHECKSUM_EN
          CSUM: begin
            if (xfer) begin
              dout_if.dout_valid <= 1'b0;
              dout_if.dout_last  <= 1'b0;
              dout_if.dout_csum  <= 1'b0;
              done               <= 1'b1;
              state              <= IDLE;
            end
          end
`endif
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ram_dump_reader.sv
// Self-checking bench for ram_dump_reader.
// Table vectors, hand corner sequences and random dumps vs a queue model.
module tb_ram_dump_reader;
  localparam int N  = 64;
  localparam int AB = 4;
  localparam int NW = 16;
`ifdef RAM_DUMP_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AB-1:0] start_addr = '0;
  logic [AB-1:0] last_addr = '0;
  logic          rd_en;
  logic [AB-1:0] rd_addr;
  logic [N-1:0]  rd_data = '0;
  logic          busy;
  logic          done;
  logic [N-1:0]  mem [NW];

  int total = 0;
  int bad = 0;

  ram_dump_reader_if #(.N(N), .ADDR_BITS(AB)) dif ();

  ram_dump_reader #(.N(N), .ADDR_BITS(AB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .start_addr (start_addr),
    .last_addr  (last_addr),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .dout_if    (dif),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM model
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

  typedef struct {
    logic [N-1:0]  data;
    logic [AB-1:0] addr;
    logic          last;
    logic          csum;
  } beat_t;

  typedef struct {
    int s;
    int l;
    int pct;
    int low;
    int abort_at;
    int cycles;
    int xfers;
  } vec_t;

  task automatic chk(input string name, input logic [N-1:0] act,
                     input logic [N-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic run_dump(input int s, input int l, input int pct,
                          input int low, input int abort_at,
                          input int exp_cycles, input int exp_xfers);
    beat_t        q[$];
    beat_t        b;
    int           n;
    int           k;
    int           last_k;
    int           xfers;
    int           dones;
    int           lo;
    bit           hold;
    bit           fin;
    logic [N-1:0] hd;
    logic [AB-1:0] ha;
    logic [N-1:0] x;
    n = ((l - s) % NW + NW) % NW + 1;
    x = '0;
    for (int i = 0; i < n; i++) begin
      b.addr = AB'((s + i) % NW);
      b.data = mem[(s + i) % NW];
      b.last = (i == n - 1) && (CS == 0);
      b.csum = 1'b0;
      x = x ^ b.data;
      q.push_back(b);
    end
    if (CS == 1) begin
      b.addr = '0;
      b.data = x;
      b.last = 1'b1;
      b.csum = 1'b1;
      q.push_back(b);
    end
    last_k = -10;
    xfers = 0;
    dones = 0;
    lo = low;
    hold = 1'b0;
    fin = 1'b0;
    hd = '0;
    ha = '0;
    @(negedge clk);
    start = 1'b1;
    start_addr = AB'(s);
    last_addr = AB'(l);
    @(negedge clk);
    start = 1'b0;
    start_addr = AB'($urandom);
    last_addr = AB'($urandom);
    chk("rd_en_first", N'(rd_en), N'(1));
    chk("rd_addr_first", N'(rd_addr), N'(s));
    k = 1;
    while (!fin && k < 2000) begin
      if (abort_at >= 0 && k == abort_at + 1) begin
        chk("abort_valid", N'(dif.dout_valid), N'(0));
        chk("abort_busy", N'(busy), N'(0));
        chk("abort_done", N'(done), N'(0));
        fin = 1'b1;
      end else if (done) begin
        dones++;
        chk("done_time", N'(k), N'(last_k + 1));
        chk("done_busy", N'(busy), N'(0));
        fin = 1'b1;
      end else begin
        if (dif.dout_valid && hold) begin
          chk("hold_data", dif.dout, hd);
          chk("hold_addr", N'(dif.dout_addr), N'(ha));
        end
        if (lo > 0 && dif.dout_valid) begin
          dif.dout_ready = 1'b0;
          lo--;
        end else begin
          dif.dout_ready = ($urandom % 100) < pct;
        end
        if (k == abort_at) begin
          abort = 1'b1;
          dif.dout_ready = 1'b1;
        end
        if (dif.dout_valid && dif.dout_ready && !abort) begin
          xfers++;
          if (q.size() == 0) begin
            chk("extra_beat", 1, 0);
          end else begin
            b = q.pop_front();
            chk("beat_data", dif.dout, b.data);
            chk("beat_addr", N'(dif.dout_addr), N'(b.addr));
            chk("beat_last", N'(dif.dout_last), N'(b.last));
            chk("beat_csum", N'(dif.dout_csum), N'(b.csum));
            if (q.size() == 0) last_k = k;
          end
        end
        hold = dif.dout_valid && !dif.dout_ready;
        hd = dif.dout;
        ha = dif.dout_addr;
        @(negedge clk);
        abort = 1'b0;
        k++;
      end
    end
    if (!fin) chk("timeout", 1, 0);
    dif.dout_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("xfers", N'(xfers), N'(exp_xfers));
    chk("dones", N'(dones), N'(abort_at >= 0 ? 0 : 1));
    if (exp_cycles > 0) chk("cycles", N'(last_k), N'(exp_cycles));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rd_en"}, N'(rd_en), N'(0));
    chk({tag, "_rd_addr"}, N'(rd_addr), N'(0));
    chk({tag, "_dout"}, dif.dout, N'(0));
    chk({tag, "_dout_addr"}, N'(dif.dout_addr), N'(0));
    chk({tag, "_valid"}, N'(dif.dout_valid), N'(0));
    chk({tag, "_last"}, N'(dif.dout_last), N'(0));
    chk({tag, "_csum"}, N'(dif.dout_csum), N'(0));
    chk({tag, "_busy"}, N'(busy), N'(0));
    chk({tag, "_done"}, N'(done), N'(0));
  endtask

  vec_t tv[6];

  initial begin
    int s;
    int l;
    int n;
    tv[0] = '{s: 0,  l: 15, pct: 100, low: 0, abort_at: -1,
              cycles: 48 + CS, xfers: 16 + CS};
    tv[1] = '{s: 14, l: 1,  pct: 100, low: 0, abort_at: -1,
              cycles: 12 + CS, xfers: 4 + CS};
    tv[2] = '{s: 5,  l: 5,  pct: 100, low: 4, abort_at: -1,
              cycles: 7 + CS, xfers: 1 + CS};
    tv[3] = '{s: 0,  l: 15, pct: 100, low: 0, abort_at: 9,
              cycles: 0, xfers: 2};
    tv[4] = '{s: 3,  l: 2,  pct: 100, low: 0, abort_at: -1,
              cycles: 48 + CS, xfers: 16 + CS};
    tv[5] = '{s: 7,  l: 9,  pct: 50,  low: 0, abort_at: -1,
              cycles: 0, xfers: 3 + CS};
    for (int i = 0; i < NW; i++) mem[i] = N'(i * 16'h0101);
    dif.dout_ready = 1'b0;

    #12;
    chk_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("idle_abort_busy", N'(busy), N'(0));

    for (int i = 0; i < 6; i++) begin
      run_dump(tv[i].s, tv[i].l, tv[i].pct, tv[i].low,
               tv[i].abort_at, tv[i].cycles, tv[i].xfers);
    end

    // Start while busy must not restart the walk.
    @(negedge clk);
    start = 1'b1;
    start_addr = 4'd2;
    last_addr = 4'd2;
    @(negedge clk);
    start_addr = 4'd9;
    last_addr = 4'd9;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("busy_start_addr", N'(dif.dout_addr), N'(2));
    chk("busy_start_data", dif.dout, mem[2]);
    dif.dout_ready = 1'b1;
    @(negedge clk);
    dif.dout_ready = 1'b0;
    for (int i = 0; i < 3 * CS + 1; i++) begin
      dif.dout_ready = 1'b1;
      @(negedge clk);
    end
    dif.dout_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("busy_start_idle", N'(busy), N'(0));

    // Reset asserted while the read is in flight.
    @(negedge clk);
    start = 1'b1;
    start_addr = 4'd6;
    last_addr = 4'd10;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("midrst_no_done", N'(done), N'(0));
    end
    run_dump(6, 10, 100, 0, -1, 15 + CS, 5 + CS);

    for (int i = 0; i < NW; i++) mem[i] = {$urandom, $urandom};
    for (int r = 0; r < 20; r++) begin
      s = $urandom_range(0, NW - 1);
      l = $urandom_range(0, NW - 1);
      n = ((l - s) % NW + NW) % NW + 1;
      run_dump(s, l, $urandom_range(40, 100), $urandom_range(0, 3),
               -1, 0, n + CS);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ram_dump_reader.md
# ram_dump_reader

Sequential read-out engine for the word-addressed RAM. On a start pulse it walks an inclusive address range and issues one read per word over the RAM's synchronous read port. Each returned word is presented on a valid/ready output stream tagged with its address. It sits between the RAM and any consumer that needs the memory contents extracted word by word, such as a trace serializer or a comparison checker.

## Interface
- N, 64, word width in bits
- ADDR_BITS, 4, address width; NUM_WORDS = 2^ADDR_BITS
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a dump; sampled only in IDLE
- abort  in  1  synchronous cancel of a dump in progress
- start_addr  in  ADDR_BITS  first address, sampled with start
- last_addr  in  ADDR_BITS  final address (inclusive), sampled with start
- rd_en  out  1  RAM read strobe, registered
- rd_addr  out  ADDR_BITS  RAM read address, registered
- rd_data  in  N  RAM read data, valid the cycle after the edge that samples rd_en
- dout  out  N  word to consumer
- dout_addr  out  ADDR_BITS  address of dout
- dout_valid  out  1  dout holds a word
- dout_ready  in  1  consumer accepts
- dout_last  out  1  final beat of the dump
- dout_csum  out  1  beat is the checksum beat; tied 0 without the macro
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse after the final beat transfers

## Operation
- States: IDLE, READ, WAIT, SEND, and CSUM (with the macro only).
- IDLE: on start=1, latch the range, set cur=start_addr, and set remaining = ((last_addr - start_addr) mod NUM_WORDS) + 1. remaining is ADDR_BITS+1 bits wide, range 1..NUM_WORDS. Go to READ.
- READ: rd_en=1, rd_addr=cur for exactly one cycle. Go to WAIT.
- WAIT: capture rd_data into dout and cur into dout_addr. Assert dout_valid. Assert dout_last when remaining==1 and the checksum feature is off. Go to SEND.
- SEND: hold dout, dout_addr and dout_valid stable until dout_valid&dout_ready.
  - On transfer with remaining>1: cur = cur+1 mod NUM_WORDS, remaining−1, go to READ.
  - On transfer with remaining==1: go to CSUM (macro) or IDLE with done pulse.
- Wrap-around: last_addr < start_addr wraps through NUM_WORDS−1 to 0.
- start_addr == last_addr reads exactly one word.
- No start/last pairing can request zero words. Reading all of NUM_WORDS requires last_addr = start_addr−1 mod NUM_WORDS.
- start while busy is ignored.
- abort while busy: next state IDLE, dout_valid=0, rd_en=0, no done. A beat pending in SEND is dropped.
- abort in IDLE has no effect.
- abort and transfer in the same cycle: abort wins and done is not pulsed.
- RAM contents are read only; this block never writes.

## Timing
- Reset values: rd_en=0, rd_addr=0, dout=0, dout_addr=0, dout_valid=0, dout_last=0, dout_csum=0, busy=0, done=0. State is IDLE and the checksum accumulator is 0.
- Reset mid-dump returns all outputs to their reset values immediately (asynchronously). No done pulse follows.
- Start accepted at edge E0:
  - rd_en=1 after E0.
  - The RAM samples at E1; rd_data is valid after E1.
  - dout_valid=1 after E2.
- Per-word cost with dout_ready held high is 3 cycles (READ, WAIT, SEND transfer). Each cycle of backpressure adds one.
- done is high for the single cycle after the final transfer edge. busy falls in that same cycle.
- dout_valid never drops without a transfer, except on abort or reset.

## Configuration
- RAM_DUMP_CHECKSUM_EN defined:
  - An N-bit XOR accumulator clears on start and folds in each word as it transfers.
  - After the last data beat, CSUM presents dout=accumulator, dout_addr=0, dout_csum=1, dout_last=1, with the same valid/ready rules.
  - done pulses after the checksum beat transfers.
  - Dump length is words+1 beats.
- RAM_DUMP_CHECKSUM_EN undefined:
  - No accumulator and no CSUM state; dout_csum is tied to 0.
  - dout_last is on the final data beat.

## Test plan
- RAM[i]=i*0x0101, start_addr=0, last_addr=15, ready=1 -> 16 beats with addresses 0..15 and matching data, dout_last on address 15, done one cycle later, 48 cycles start-to-last transfer.
- start_addr=14, last_addr=1 -> beats in order for addresses 14, 15, 0, 1; dout_last on address 1.
- start_addr=last_addr=5, dout_ready low for 4 cycles after valid -> dout and dout_addr stable throughout, exactly one beat, done after the transfer.
- abort asserted in SEND of the third word -> dout_valid drops the next cycle, busy=0, no done; a following start runs normally.
- rst_n low during WAIT -> all outputs at reset values immediately; start after release works.
- With RAM_DUMP_CHECKSUM_EN, words 0x0F, 0xF0, 0xFF at addresses 0..2 -> three data beats, then a checksum beat with dout=0x00, dout_csum=1, dout_last=1.
